// File: rtl/pipelined_accum_adder_tree_if.sv
// Lane-vector request and result bus for the pipelined accumulating adder tree.
interface pipelined_accum_adder_tree_if #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH   = 16
);
  logic                                   in_valid;
  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] inputs;
  logic [INPUT_WIDTH-1:0]                 bias;
  logic                                   acc_mode;
  logic                                   in_last;
  logic [ACC_WIDTH-1:0]                   out;
  logic                                   out_valid;
  logic                                   out_sat;

  modport master (
    output in_valid, inputs, bias, acc_mode, in_last,
    input  out, out_valid, out_sat
  );

  modport slave (
    input  in_valid, inputs, bias, acc_mode, in_last,
    output out, out_valid, out_sat
  );
endinterface

// File: rtl/pipelined_accum_adder_tree.sv
// Fully pipelined unsigned adder tree with bias, valid-qualified bubbles and a
// saturating multi-beat accumulate mode; latency is log2(NUM_INPUTS)+1 cycles.
module pipelined_accum_adder_tree #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pipelined_accum_adder_tree_if.slave   bus
);
  localparam int unsigned L      = $clog2(NUM_INPUTS);
  localparam int unsigned SUM_W  = INPUT_WIDTH + L;
  localparam int unsigned ACC_W1 = ACC_WIDTH + 1;

  if ((1 << L) != NUM_INPUTS || NUM_INPUTS < 2) begin : g_bad_lanes
    $error("NUM_INPUTS must be a power of two and at least 2");
  end
  if (ACC_WIDTH < INPUT_WIDTH + L + 1) begin : g_bad_acc
    $error("ACC_WIDTH must be at least INPUT_WIDTH + log2(NUM_INPUTS) + 1");
  end

  typedef struct packed {
    logic                   valid;
    logic                   acc_mode;
    logic                   last;
    logic [INPUT_WIDTH-1:0] bias;
  } side_t;

  side_t side_in;
  side_t side_q [1:L];

  assign side_in = '{valid: bus.in_valid, acc_mode: bus.acc_mode,
                     last: bus.in_last, bias: bus.bias};

  // Sideband travels in lockstep with the tree levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= int'(L); i++) side_q[i] <= '0;
    end else begin
      side_q[1] <= side_in;
      for (int i = 2; i <= int'(L); i++) side_q[i] <= side_q[i-1];
    end
  end

  // Level k holds NUM_INPUTS>>k partial sums of INPUT_WIDTH+k bits each.
  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int unsigned W = INPUT_WIDTH + k;
    localparam int unsigned N = NUM_INPUTS >> k;
    logic [N-1:0][W-1:0] sum;
    if (k == 0) begin : g_leaf
      assign sum = bus.inputs;
    end else begin : g_add
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sum <= '0;
        end else begin
          for (int i = 0; i < int'(N); i++)
            sum[i] <= W'(g_lvl[k-1].sum[2*i]) + W'(g_lvl[k-1].sum[2*i+1]);
        end
      end
    end
  end

  logic [SUM_W-1:0] tree_sum;
  side_t            fin;
  assign tree_sum = g_lvl[L].sum[0];
  assign fin      = side_q[L];

  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_q, out_d, base, acc_clip;
  logic                 open_q, open_d, sat_q, sat_d;
  logic                 out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [ACC_W1-1:0]    acc_sum;
  logic                 clip;

  // Final stage: single-vector result or saturating packet accumulate.
  always_comb begin
    acc_d       = acc_q;
    open_d      = open_q;
    sat_d       = sat_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_sat_d   = out_sat_q;
    base        = open_q ? acc_q : '0;
    acc_sum     = ACC_W1'(base) + ACC_W1'(tree_sum)
                + (fin.last ? ACC_W1'(fin.bias) : ACC_W1'(0));
    clip        = acc_sum[ACC_WIDTH];
    acc_clip    = clip ? '1 : acc_sum[ACC_WIDTH-1:0];
    if (fin.valid) begin
      if (!fin.acc_mode) begin
        out_d       = ACC_WIDTH'(tree_sum) + ACC_WIDTH'(fin.bias);
        out_valid_d = 1'b1;
        out_sat_d   = 1'b0;
      end else if (fin.last) begin
        out_d       = acc_clip;
        out_valid_d = 1'b1;
        out_sat_d   = sat_q | clip;
        acc_d       = '0;
        open_d      = 1'b0;
        sat_d       = 1'b0;
      end else begin
        acc_d  = acc_clip;
        open_d = 1'b1;
        sat_d  = sat_q | clip;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      open_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      open_q      <= open_d;
      sat_q       <= sat_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sat   = out_sat_q;
endmodule
